// File: rtl/sys_top_pkg.sv
// Shared constants and types for the UART-to-GPIO bridge.
// Command bytes, reply bytes, parser states and pad width.
package sys_top_pkg;

    localparam int GPIO_W = 9;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_DIR   = 8'h44;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG_HI,
        ST_ARG_LO,
        ST_EXEC,
        ST_RESP
    } pstate_t;

    function automatic logic [GPIO_W-1:0] pack_arg(
        input logic       hi0,
        input logic [7:0] lo
    );
        return {hi0, lo};
    endfunction

endpackage

// File: rtl/sys_uart.sv
// 8N1 UART receiver and transmitter sharing one bit period.
// rxd must already be synchronised; txd comes straight from a flop.
module sys_uart #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_t;

    rx_t           rx_st, rx_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_sh, rx_sh_nx;
    logic          rx_prev;
    logic          rx_vld_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st    <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_prev  <= 1'b1;
            rx_valid <= 1'b0;
        end else begin
            rx_st    <= rx_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_sh    <= rx_sh_nx;
            rx_prev  <= rxd;
            rx_valid <= rx_vld_nx;
        end
    end

    // Start bit is re-checked half a bit after the edge; data at mid-bit.
    always_comb begin
        rx_nx     = rx_st;
        rx_cnt_nx = rx_cnt + 1'b1;
        rx_bit_nx = rx_bit;
        rx_sh_nx  = rx_sh;
        rx_vld_nx = 1'b0;
        unique case (rx_st)
            RX_IDLE: begin
                rx_cnt_nx = '0;
                if (rx_prev && !rxd)
                    rx_nx = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_nx = '0;
                    rx_bit_nx = '0;
                    rx_nx     = rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_nx = '0;
                    rx_sh_nx  = {rxd, rx_sh[7:1]};
                    rx_bit_nx = rx_bit + 1'b1;
                    if (rx_bit == 3'd7)
                        rx_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_nx = '0;
                    rx_vld_nx = rxd;
                    rx_nx     = RX_IDLE;
                end
            end
            default: rx_nx = RX_IDLE;
        endcase
    end

    assign rx_data = rx_sh;

    tx_t           tx_st, tx_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [3:0]    tx_bit, tx_bit_nx;
    logic [9:0]    tx_sh, tx_sh_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '1;
        end else begin
            tx_st  <= tx_nx;
            tx_cnt <= tx_cnt_nx;
            tx_bit <= tx_bit_nx;
            tx_sh  <= tx_sh_nx;
        end
    end

    // Ready in the last stop-bit cycle so queued bytes follow gaplessly.
    always_comb begin
        tx_nx     = tx_st;
        tx_cnt_nx = tx_cnt;
        tx_bit_nx = tx_bit;
        tx_sh_nx  = tx_sh;
        tx_ready  = 1'b0;
        unique case (tx_st)
            TX_IDLE: begin
                tx_ready = 1'b1;
            end
            TX_SEND: begin
                tx_cnt_nx = tx_cnt + 1'b1;
                if (tx_cnt == LAST) begin
                    tx_cnt_nx = '0;
                    if (tx_bit == 4'd9) begin
                        tx_ready = 1'b1;
                        tx_nx    = TX_IDLE;
                        tx_sh_nx = '1;
                    end else begin
                        tx_bit_nx = tx_bit + 1'b1;
                        tx_sh_nx  = {1'b1, tx_sh[9:1]};
                    end
                end
            end
            default: tx_nx = TX_IDLE;
        endcase
        if (tx_ready && tx_valid) begin
            tx_nx     = TX_SEND;
            tx_cnt_nx = '0;
            tx_bit_nx = '0;
            tx_sh_nx  = {1'b1, tx_data, 1'b0};
        end
    end

    assign tx_busy = (tx_st == TX_SEND);
    assign txd     = tx_sh[0];

endmodule

// File: rtl/sys_top.sv
// Board top: UART command parser driving a 9-bit tri-state GPIO port.
// Owns reset/input synchronisers, GPIO registers and the pad drivers.
module sys_top
    import sys_top_pkg::*;
#(
    parameter int CLK_HZ = 200000000,
    parameter int BAUD   = 115200
) (
    input  logic              diff_clk_200mhz_clk_p,
    input  logic              diff_clk_200mhz_clk_n,
    input  logic              reset,
    inout  wire  [GPIO_W-1:0] gpio,
    input  logic              uart_rxd,
    output logic              uart_txd
);

    localparam int DIV = CLK_HZ / BAUD;

    logic clk;
    logic unused_clk_n;

    assign clk          = diff_clk_200mhz_clk_p;
    assign unused_clk_n = diff_clk_200mhz_clk_n;

    // Asynchronous assert, two-flop synchronised release.
    logic [1:0] rst_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rst_q <= 2'b00;
        else
            rst_q <= {rst_q[0], 1'b1};
    end

    assign rst_n = rst_q[1];

    logic [1:0]        rxd_q;
    logic [GPIO_W-1:0] gpio_m, gpio_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q  <= 2'b11;
            gpio_m <= '0;
            gpio_s <= '0;
        end else begin
            rxd_q  <= {rxd_q[0], uart_rxd};
            gpio_m <= gpio;
            gpio_s <= gpio_m;
        end
    end

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;

    sys_uart #(
        .DIV(DIV)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd_q[1]),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .txd      (uart_txd)
    );

    pstate_t           st_q, st_nx;
    logic [7:0]        cmd_q, cmd_nx;
    logic              hi_q, hi_nx;
    logic [7:0]        lo_q, lo_nx;
    logic [GPIO_W-1:0] out_q, out_nx;
    logic [GPIO_W-1:0] dir_q, dir_nx;
    logic [7:0]        rsp0_q, rsp0_nx;
    logic [7:0]        rsp1_q, rsp1_nx;
    logic [1:0]        rsp_n_q, rsp_n_nx;
    logic [1:0]        rsp_i_q, rsp_i_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            cmd_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            rsp0_q  <= '0;
            rsp1_q  <= '0;
            rsp_n_q <= '0;
            rsp_i_q <= '0;
        end else begin
            st_q    <= st_nx;
            cmd_q   <= cmd_nx;
            hi_q    <= hi_nx;
            lo_q    <= lo_nx;
            out_q   <= out_nx;
            dir_q   <= dir_nx;
            rsp0_q  <= rsp0_nx;
            rsp1_q  <= rsp1_nx;
            rsp_n_q <= rsp_n_nx;
            rsp_i_q <= rsp_i_nx;
        end
    end

    always_comb begin
        st_nx    = st_q;
        cmd_nx   = cmd_q;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        out_nx   = out_q;
        dir_nx   = dir_q;
        rsp0_nx  = rsp0_q;
        rsp1_nx  = rsp1_q;
        rsp_n_nx = rsp_n_q;
        rsp_i_nx = rsp_i_q;
        tx_valid = 1'b0;
        tx_data  = rsp_i_q[0] ? rsp1_q : rsp0_q;
        unique case (st_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    cmd_nx = rx_data;
                    if (rx_data == CMD_WRITE || rx_data == CMD_DIR)
                        st_nx = ST_ARG_HI;
                    else
                        st_nx = ST_EXEC;
                end
            end
            ST_ARG_HI: begin
                if (rx_valid) begin
                    hi_nx = rx_data[0];
                    st_nx = ST_ARG_LO;
                end
            end
            ST_ARG_LO: begin
                if (rx_valid) begin
                    lo_nx = rx_data;
                    st_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_i_nx = '0;
                rsp_n_nx = 2'd1;
                rsp0_nx  = RSP_OK;
                unique case (1'b1)
                    cmd_q == CMD_WRITE: out_nx = pack_arg(hi_q, lo_q);
                    cmd_q == CMD_DIR:   dir_nx = pack_arg(hi_q, lo_q);
                    cmd_q == CMD_READ: begin
                        rsp0_nx  = {7'b0, gpio_s[8]};
                        rsp1_nx  = gpio_s[7:0];
                        rsp_n_nx = 2'd2;
                    end
                    default: rsp0_nx = RSP_ERR;
                endcase
                st_nx = ST_RESP;
            end
            ST_RESP: begin
                // Hold here until the last byte has left the line.
                if (rsp_i_q != rsp_n_q) begin
                    tx_valid = 1'b1;
                    if (tx_ready)
                        rsp_i_nx = rsp_i_q + 2'd1;
                end else if (!tx_busy) begin
                    st_nx = ST_IDLE;
                end
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < GPIO_W; i++) begin : g_pad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_sys_top.sv
// Self-checking bench for sys_top at 16 clocks per UART bit.
// Replies are checked sample-by-sample against ideal 8N1 frames.
module tb_sys_top;

    localparam int DIV = 16;
    localparam int FW  = 10 * DIV;

    logic       clk_p;
    wire        clk_n;
    logic       reset;
    logic       rxd;
    logic       txd;
    wire  [8:0] gpio;
    logic [8:0] tb_drv;
    logic [8:0] tb_en;

    for (genvar i = 0; i < 9; i++) begin : g_drv
        assign gpio[i] = tb_en[i] ? tb_drv[i] : 1'bz;
    end

    sys_top #(
        .CLK_HZ(1600000),
        .BAUD  (100000)
    ) dut (
        .diff_clk_200mhz_clk_p(clk_p),
        .diff_clk_200mhz_clk_n(clk_n),
        .reset                (reset),
        .gpio                 (gpio),
        .uart_rxd             (rxd),
        .uart_txd             (txd)
    );

    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    int total = 0;
    int bad   = 0;

    logic cap = 1'b0;
    logic txq[$];

    always @(negedge clk_p) if (cap) txq.push_back(txd);

    logic [8:0] m_out;
    logic [8:0] m_dir;
    logic [7:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_p);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stopv;
        tick(DIV);
        rxd = 1'b1;
    endtask

    task automatic start_cap();
        txq.delete();
        cap = 1'b1;
    endtask

    // Find the first start bit, then demand exact frames and a quiet tail.
    task automatic check_reply(input string tag);
        int st;
        int n;
        int zeros;
        logic [FW-1:0] o;
        logic [FW-1:0] e;
        logic [9:0] fr;
        cap = 1'b0;
        st = -1;
        n = exp_q.size();
        foreach (txq[i]) if (st < 0 && txq[i] === 1'b0) st = i;
        chk({tag, ":start"}, FW'(st >= 0), FW'(n != 0));
        if (st >= 0 && n != 0) begin
            for (int k = 0; k < n; k++) begin
                fr = {1'b1, exp_q[k], 1'b0};
                for (int j = 0; j < 10; j++) begin
                    for (int s = 0; s < DIV; s++) begin
                        int idx;
                        idx = st + k * FW + j * DIV + s;
                        e[j*DIV+s] = fr[j];
                        o[j*DIV+s] = (idx < txq.size()) ? txq[idx] : 1'bx;
                    end
                end
                chk($sformatf("%s:byte%0d", tag, k), o, e);
            end
            zeros = 0;
            for (int i = st + n * FW; i < txq.size(); i++)
                if (txq[i] !== 1'b1) zeros++;
            chk({tag, ":tail"}, FW'(zeros), '0);
        end
    endtask

    function automatic logic [8:0] pads();
        return (m_dir & m_out) | (~m_dir & tb_drv);
    endfunction

    task automatic do_cmd(input string tag, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2);
        logic [8:0] v;
        logic [8:0] rd;
        bit two;
        exp_q.delete();
        two = (b0 == 8'h57 || b0 == 8'h44);
        v = {b1[0], b2};
        rd = pads();
        if (b0 == 8'h57) begin
            m_out = v;
            exp_q.push_back(8'h4B);
        end else if (b0 == 8'h44) begin
            m_dir = v;
            tb_en = tb_en & ~v;
            exp_q.push_back(8'h4B);
        end else if (b0 == 8'h52) begin
            exp_q.push_back({7'b0, rd[8]});
            exp_q.push_back(rd[7:0]);
        end else begin
            exp_q.push_back(8'h3F);
        end
        start_cap();
        send_byte(b0, 1'b1);
        if (two) begin
            send_byte(b1, 1'b1);
            send_byte(b2, 1'b1);
        end
        tick((exp_q.size() * 10 + 4) * DIV);
        check_reply(tag);
        tb_en = ~m_dir;
        tick(2);
        chk({tag, ":pads"}, FW'(gpio), FW'(pads()));
    endtask

    task automatic hard_reset(input int n);
        reset = 1'b0;
        rxd   = 1'b1;
        m_out = '0;
        m_dir = '0;
        tb_en = '1;
        tick(n);
        reset = 1'b1;
        tick(4);
    endtask

    initial begin
        int found;
        reset  = 1'b0;
        rxd    = 1'b1;
        tb_en  = '0;
        tb_drv = 9'($urandom);
        m_out  = '0;
        m_dir  = '0;
        tick(5);
        chk("rst_txd", FW'(txd), FW'(1));
        tb_en = '1;
        reset = 1'b1;
        exp_q.delete();
        start_cap();
        tick(20 * DIV);
        check_reply("rst_quiet");
        chk("rst_pads", FW'(gpio), FW'(tb_drv));

        do_cmd("dir_all", 8'h44, 8'h01, 8'hFF);
        do_cmd("write", 8'h57, 8'h01, 8'h5A);
        chk("gpio_15a", FW'(gpio), FW'(9'h15A));

        do_cmd("dir_none", 8'h44, 8'hFE, 8'h00);
        tb_drv = 9'h0A5;
        do_cmd("read_a5", 8'h52, 8'h00, 8'h00);
        do_cmd("unknown", 8'h11, 8'h00, 8'h00);

        exp_q.delete();
        start_cap();
        send_byte(8'h52, 1'b0);
        tick(15 * DIV);
        check_reply("framing");

        start_cap();
        rxd = 1'b0;
        tick(DIV / 2 - 2);
        rxd = 1'b1;
        tick(15 * DIV);
        check_reply("glitch");

        start_cap();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        rxd = 1'b0;
        tick(DIV + DIV / 2);
        hard_reset(10);
        tick(15 * DIV);
        check_reply("rst_mid");
        tb_drv = 9'h133;
        do_cmd("read_after", 8'h52, 8'h00, 8'h00);
        do_cmd("dir_all2", 8'h44, 8'h01, 8'hFF);
        do_cmd("read_out0", 8'h52, 8'h00, 8'h00);

        start_cap();
        send_byte(8'h52, 1'b1);
        found = 0;
        for (int i = 0; i < 4 * DIV && found == 0; i++) begin
            if (txd === 1'b0) found = 1;
            else tick(1);
        end
        chk("tx_started", FW'(found), FW'(1));
        cap = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        chk("tx_async_rst", FW'(txd), FW'(1));
        hard_reset(10);
        exp_q.delete();
        start_cap();
        tick(15 * DIV);
        check_reply("tx_rst_quiet");

        for (int i = 0; i < 14; i++) begin
            logic [7:0] b0;
            case ($urandom_range(0, 3))
                0:       b0 = 8'h57;
                1:       b0 = 8'h44;
                2:       b0 = 8'h52;
                default: b0 = 8'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) tb_drv = 9'($urandom);
            tick(2);
            do_cmd($sformatf("rnd%0d", i), b0, 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
